// File: rtl/sap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sap_ctrl_pkg
// Shared definitions for the SAP-1 hardwired control sequencer:
//   - opcode constants for the decoded instructions
//   - sequencer state enumeration (PAUSE exists only with SAP_SINGLE_STEP_EN)
//   - control-word bit indices (bit 16 = EP down to bit 0 = LO*)
//   - every control-word value the sequencer can emit
//   - t_onehot(): maps a state onto the one-hot T1..T6 indicator
// Configuration macro: SAP_SINGLE_STEP_EN (adds the PAUSE state).
// ---------------------------------------------------------------------------
package sap_ctrl_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'h3;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_T1    = 4'd1,
        ST_T2    = 4'd2,
        ST_T3    = 4'd3,
        ST_T4    = 4'd4,
        ST_T5    = 4'd5,
        ST_T6    = 4'd6,
`ifdef SAP_SINGLE_STEP_EN
        ST_HALT  = 4'd7,
        ST_PAUSE = 4'd8
`else
        ST_HALT  = 4'd7
`endif
    } state_t;

    // Control-word bit positions; _N marks active-low strobes.
    localparam int CW_EP    = 16;
    localparam int CW_CP    = 15;
    localparam int CW_LM_N  = 14;
    localparam int CW_CE_N  = 13;
    localparam int CW_LI_N  = 12;
    localparam int CW_EI    = 11;
    localparam int CW_CS    = 10;
    localparam int CW_LOAD  = 9;
    localparam int CW_CLR   = 8;
    localparam int CW_INC   = 7;
    localparam int CW_LA_N  = 6;
    localparam int CW_EA    = 5;
    localparam int CW_LB_N  = 4;
    localparam int CW_SU    = 3;
    localparam int CW_AD    = 2;
    localparam int CW_EU    = 1;
    localparam int CW_LO_N  = 0;

    // Inactive word: all active-low strobes high, everything else low.
    localparam logic [16:0] CW_IDLE   = 17'h07051;
    localparam logic [16:0] CW_T1     = 17'h13051;  // EP, LM
    localparam logic [16:0] CW_T2     = 17'h0F051;  // CP
    localparam logic [16:0] CW_T3     = 17'h04051;  // CE, LI
    localparam logic [16:0] CW_T4_MEM = 17'h03851;  // EI, LM (operand address)
    localparam logic [16:0] CW_T4_OUT = 17'h07070;  // EA, LO
    localparam logic [16:0] CW_T5_LDA = 17'h05011;  // CE, LA
    localparam logic [16:0] CW_T5_LDB = 17'h05041;  // CE, LB
    localparam logic [16:0] CW_T6_ADD = 17'h07017;  // AD, EU, LA
    localparam logic [16:0] CW_T6_SUB = 17'h0701B;  // SU, EU, LA

    // Bit 0 = T1 ... bit 5 = T6; zero in every non-T state.
    function automatic logic [5:0] t_onehot(input state_t s);
        logic [5:0] t;
        t = 6'b000000;
        case (s)
            ST_T1:   t = 6'b000001;
            ST_T2:   t = 6'b000010;
            ST_T3:   t = 6'b000100;
            ST_T4:   t = 6'b001000;
            ST_T5:   t = 6'b010000;
            ST_T6:   t = 6'b100000;
            default: t = 6'b000000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/sap_cw_decode.sv
// ---------------------------------------------------------------------------
// sap_cw_decode
// Purely combinational control-word decoder for the SAP-1 sequencer.
// Ports:
//   state  : current registered sequencer state
//   opcode : live IR opcode, used only in T4 (IR is loaded at end of T3)
//   op_r   : opcode captured at the end of T4, used in T5/T6
//   cw     : CW_W-bit control word to the datapath
// ---------------------------------------------------------------------------
module sap_cw_decode
    import sap_ctrl_pkg::*;
#(
    parameter int CW_W = 17
) (
    input  state_t          state,
    input  logic [3:0]      opcode,
    input  logic [3:0]      op_r,
    output logic [CW_W-1:0] cw
);

    always_comb begin
        cw = CW_W'(CW_IDLE);
        case (state)
            ST_T1: cw = CW_W'(CW_T1);
            ST_T2: cw = CW_W'(CW_T2);
            ST_T3: cw = CW_W'(CW_T3);
            ST_T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: cw = CW_W'(CW_T4_MEM);
                    OP_OUT:                 cw = CW_W'(CW_T4_OUT);
                    default:                cw = CW_W'(CW_IDLE);
                endcase
            end
            ST_T5: begin
                case (op_r)
                    OP_LDA:         cw = CW_W'(CW_T5_LDA);
                    OP_ADD, OP_SUB: cw = CW_W'(CW_T5_LDB);
                    default:        cw = CW_W'(CW_IDLE);
                endcase
            end
            ST_T6: begin
                case (op_r)
                    OP_ADD:  cw = CW_W'(CW_T6_ADD);
                    OP_SUB:  cw = CW_W'(CW_T6_SUB);
                    default: cw = CW_W'(CW_IDLE);
                endcase
            end
            default: cw = CW_W'(CW_IDLE);
        endcase
    end

endmodule

// File: rtl/sap_hardwired_sequencer.sv
// ---------------------------------------------------------------------------
// sap_hardwired_sequencer
// Hardwired T1..T6 ring controller for the 8-bit SAP-1 datapath.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   run             : start request, honoured only in IDLE
//   opcode          : IR[8:5], valid from T4 onward
//   step_mode, step : single-step controls (only with SAP_SINGLE_STEP_EN)
//   cw              : control word decoded from registered state and op_r
//   t_state         : one-hot T1..T6 (bit 0 = T1), zero outside the ring
//   busy            : high in T1..T6
//   halted          : high in HALT
//   instr_cnt       : retired-instruction counter, wraps modulo 2^CNT_W
// Configuration macro: SAP_SINGLE_STEP_EN adds the step ports and a PAUSE
// state entered after T6 when step_mode is set.
// ---------------------------------------------------------------------------
module sap_hardwired_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int CW_W  = 17,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [3:0]       opcode,
`ifdef SAP_SINGLE_STEP_EN
    input  logic             step_mode,
    input  logic             step,
`endif
    output logic [CW_W-1:0]  cw,
    output logic [5:0]       t_state,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t             state_q, state_d;
    logic [3:0]         op_r_q, op_r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        op_r_d  = op_r_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3:   state_d = ST_T4;
            ST_T4: begin
                if (opcode == OP_HLT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_T5;
                    // IR may change later; T5/T6 decode from this copy.
                    op_r_d  = opcode;
                end
            end
            ST_T5:   state_d = ST_T6;
            ST_T6: begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef SAP_SINGLE_STEP_EN
                state_d = step_mode ? ST_PAUSE : ST_T1;
`else
                state_d = ST_T1;
`endif
            end
            ST_HALT: state_d = ST_HALT;
`ifdef SAP_SINGLE_STEP_EN
            // Dropping step_mode while paused releases the ring as well.
            ST_PAUSE: if (step || !step_mode) state_d = ST_T1;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // op_r is only read in T5/T6, which are always preceded by a T4 capture.
    always_ff @(posedge clk) begin
        op_r_q <= op_r_d;
    end

    sap_cw_decode #(
        .CW_W (CW_W)
    ) u_cw_decode (
        .state  (state_q),
        .opcode (opcode),
        .op_r   (op_r_q),
        .cw     (cw)
    );

    assign t_state   = t_onehot(state_q);
    assign busy      = |t_state;
    assign halted    = (state_q == ST_HALT);
    assign instr_cnt = cnt_q;

endmodule

// File: doc/sap_hardwired_sequencer.md
# sap_hardwired_sequencer

Hardwired control sequencer for the 8-bit SAP-1 datapath (PC, MAR, SRAM, IR, accumulator, B register, ALU, output register), an alternative to the microprogrammed control ROM path. It steps a T1–T6 ring of states per instruction. It decodes the IR opcode and drives the same 17-bit control word the datapath already consumes. It also provides run/halt control and counts retired instructions.

## Interface
Parameters:
- `CW_W`, 17, control-word width; bit order EP CP LM* CE* LI* EI CS LOAD CLR INC LA* EA LB* SU AD EU LO* (bit 16 down to 0; * = active-low)
- `CNT_W`, 8, width of the retired-instruction counter

Ports:
- `clk` input 1: single system clock; all state updates on the rising edge
- `rst` input 1: synchronous, active-high reset
- `run` input 1: start request, sampled only in IDLE
- `opcode` input 4: IR[8:5], valid from T4 onward
- `cw` output CW_W: registered-state-decoded control word to the datapath
- `t_state` output 6: one-hot T1..T6; all-zero when not in T1..T6
- `busy` output 1: high in T1..T6
- `halted` output 1: high in HALT
- `instr_cnt` output CNT_W: count of completed instructions
- `step_mode`, `step` input 1 each: present only with `SAP_SINGLE_STEP_EN`

## Operation
States: IDLE, T1, T2, T3, T4, T5, T6, HALT, plus PAUSE (only with the macro).
- IDLE: leaves to T1 when `run`=1; otherwise stays.
- T1→T2→T3→T4 unconditionally.
- T4: HLT opcode (4'hF) → HALT. Otherwise → T5, and `opcode` is captured into `op_r` for use in T5/T6.
- T5→T6. T6 → T1, and `instr_cnt` increments (wraps modulo 2^CNT_W).
- HALT: absorbing; exits only on `rst`.

Control words (hex, 17-bit). Inactive word `CW_IDLE`=17'h07051 is driven in IDLE, HALT, PAUSE and all unlisted slots.
- T1: 17'h13051 (EP, LM)
- T2: 17'h0F051 (CP)
- T3: 17'h04051 (CE, LI)
- LDA (0): T4 17'h03851 (EI, LM); T5 17'h05011 (CE, LA); T6 idle
- ADD (1): T4 17'h03851; T5 17'h05041 (CE, LB); T6 17'h07017 (AD, EU, LA)
- SUB (2): T4 17'h03851; T5 17'h05041; T6 17'h0701B (SU, EU, LA)
- OUT (3): T4 17'h07070 (EA, LO); T5, T6 idle
- Opcodes 4..E: NOP, idle word in T4–T6, still counted as retired
- CS, LOAD, CLR, INC bits are always 0.

## Timing
- Reset (any state, mid-instruction included): next edge → IDLE, `cw`=17'h07051, `t_state`=0, `busy`=0, `halted`=0, `instr_cnt`=0. `rst` has priority over `run`/`step`.
- `cw` is a combinational decode of the registered state and `op_r`; it is glitch-free relative to `clk` at the datapath register inputs.
- In T4, decoding uses live `opcode`; T5/T6 use `op_r`.
- Instruction latency: exactly 6 cycles from T1 to the next T1. HLT reaches HALT after T4 (4 cycles).
- `run` held high continuously has no effect outside IDLE.

## Configuration
- `SAP_SINGLE_STEP_EN` defined: adds `step_mode` and `step` ports and a PAUSE state.
  - T6 with `step_mode`=1 → PAUSE (counter still increments).
  - PAUSE → T1 on `step`=1.
  - Clearing `step_mode` while in PAUSE also resumes to T1 on the next edge.
  - HLT behaviour is unchanged.
- Undefined: no PAUSE state and no step ports; T6 always → T1.

## Structure
- Package `sap_ctrl_pkg`: opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT), state enum, CW bit-index constants, and all CW hex constants above.
- Sub-module `sap_cw_decode`: purely combinational (state, opcode, op_r) → cw. The top module holds the state register, `op_r`, and `instr_cnt`.

## Test plan
- Reset, `run`=0 for 5 cycles → `cw`=17'h07051, `t_state`=0, `busy`=0.
- `run` pulse, `opcode`=0 at T4 → `cw` sequence 13051, 0F051, 04051, 03851, 05011, 07051; then T1 again; `instr_cnt`=1.
- `opcode`=2 → T6 `cw`=17'h0701B. `opcode` changed to 1 during T5 → T6 still 17'h0701B (`op_r` held).
- `opcode`=4'hF at T4 → `halted`=1 next cycle, `cw`=17'h07051, `run` ignored; `rst` → IDLE.
- `rst` asserted in T5 of ADD → next cycle IDLE, `instr_cnt`=0, no LA pulse issued.
- Macro on, `step_mode`=1 → PAUSE after T6 with idle `cw`. `step` pulse → T1 next cycle. 256 instructions → `instr_cnt` wraps to 0.
